// File: rtl/sm83_bus_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sm83_bus_ctrl : SM83 bus front end - T1..T4 phasing, wait/timeout,       |
// |                 address/data latches, instruction register, lock-up flag |
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
module sm83_bus_ctrl #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int HI_CLR_BITS = 8,
  parameter int MAX_WAIT    = 15
) (
  input  logic              clk,
  input  logic              reset,
  output logic              t1,
  output logic              t2,
  output logic              t3,
  output logic              t4,
  output logic              stall,
  input  logic              mread,
  input  logic              mwrite,
  input  logic              ext_ready,
  output logic              rd,
  output logic              wr,
  output logic              bus_err,
  input  logic [ADDR_W-1:0] ain,
  input  logic              apin_we,
  output logic [ADDR_W-1:0] aout,
  input  logic [DATA_W-1:0] din,
  input  logic              dl_we,
  output logic [DATA_W-1:0] dout,
  output logic [DATA_W-1:0] ext_dout,
  input  logic [DATA_W-1:0] ext_din,
  input  logic              vec_sel,
  input  logic [DATA_W-1:0] vec_data,
  input  logic              ctl_zero_data_oe,
  input  logic              ctl_ir_we,
  input  logic              ctl_ir_bank_we,
  input  logic              ctl_ir_bank_cb_set,
  output logic [DATA_W-1:0] opcode,
  output logic              bank_cb,
  output logic              ill_op
);

  localparam int c_WCW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

  localparam logic [1:0] c_T1 = 2'd0;
  localparam logic [1:0] c_T2 = 2'd1;
  localparam logic [1:0] c_T3 = 2'd2;
  localparam logic [1:0] c_T4 = 2'd3;

  localparam logic [c_WCW-1:0]  c_WAIT_LIMIT = c_WCW'(MAX_WAIT);
  // Upper HI_CLR_BITS of the address; evaluates to 0 when HI_CLR_BITS==0.
  localparam logic [ADDR_W-1:0] c_HI_MASK    = ~({ADDR_W{1'b1}} >> HI_CLR_BITS);

  logic [1:0]        r_state;
  logic [c_WCW-1:0]  r_wait_cnt;
  logic              r_timeout;
  logic              r_rd;
  logic              r_wr;
  logic [ADDR_W-1:0] r_aout;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] r_opcode;
  logic              r_bank_cb;
  logic              r_ill_op;

  logic              w_busy;
  logic              w_at_limit;
  logic              w_t3_done;
  logic              w_is_t4;
  logic              w_rd_t4;
  logic [DATA_W-1:0] w_data_t4;
  logic              w_ill_code;
  logic              w_ill_hit;

  assign w_busy     = r_rd | r_wr;
  assign w_at_limit = (r_wait_cnt == c_WAIT_LIMIT);
  assign w_t3_done  = !w_busy || ext_ready || w_at_limit;
  assign w_is_t4    = (r_state == c_T4);
  assign w_rd_t4    = r_rd && w_is_t4;

  // Phase FSM; the timeout flag is captured on the forced T3->T4 exit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= c_T4;
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      case (r_state)
        c_T1: r_state <= c_T2;
        c_T2: r_state <= c_T3;
        c_T3: begin
          if (w_t3_done) begin
            r_state   <= c_T4;
            r_timeout <= w_busy && !ext_ready && w_at_limit;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        c_T4: begin
          r_state    <= c_T1;
          r_wait_cnt <= '0;
          r_timeout  <= 1'b0;
        end
        default: r_state <= c_T4;
      endcase
    end
  end

  // Requests are sampled only at T4; a read request wins over a write.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd <= 1'b0;
      r_wr <= 1'b0;
    end else if (w_is_t4) begin
      r_rd <= mread && !r_ill_op;
      r_wr <= mwrite && !mread && !r_ill_op;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_aout <= '0;
    end else if (apin_we) begin
      r_aout <= ain;
    end else if (w_is_t4) begin
      r_aout <= r_aout & ~c_HI_MASK;
    end
  end

  always_comb begin
    w_data_t4 = vec_sel ? vec_data : ext_din;
    if (r_timeout && r_rd) begin
      w_data_t4 = '1;
    end
    if (ctl_zero_data_oe) begin
      w_data_t4 = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data <= '0;
    end else if (ctl_zero_data_oe) begin
      r_data <= '0;
    end else if (dl_we) begin
      r_data <= din;
    end else if (w_rd_t4) begin
      r_data <= w_data_t4;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_opcode  <= '0;
      r_bank_cb <= 1'b0;
    end else begin
      if (ctl_ir_we) begin
        r_opcode <= w_data_t4;
      end
      if (ctl_ir_bank_we) begin
        r_bank_cb <= ctl_ir_bank_cb_set;
      end
    end
  end

  // Unused base-page opcodes lock the core up; only meaningful for 8-bit data.
  if (DATA_W == 8) begin : g_ill_dec
    always_comb begin
      case (w_data_t4)
        8'hD3, 8'hDB, 8'hDD, 8'hE3, 8'hE4, 8'hEB,
        8'hEC, 8'hED, 8'hF4, 8'hFC, 8'hFD: w_ill_code = 1'b1;
        default:                           w_ill_code = 1'b0;
      endcase
    end
  end else begin : g_ill_none
    assign w_ill_code = 1'b0;
  end

  assign w_ill_hit = ctl_ir_we && !r_bank_cb && w_ill_code;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ill_op <= 1'b0;
    end else if (w_ill_hit) begin
      r_ill_op <= 1'b1;
    end
  end

  assign t1       = (r_state == c_T1);
  assign t2       = (r_state == c_T2);
  assign t3       = (r_state == c_T3);
  assign t4       = w_is_t4;
  assign stall    = (r_state == c_T3) && !w_t3_done;
  assign rd       = r_rd;
  assign wr       = r_wr;
  assign bus_err  = w_is_t4 && r_timeout;
  assign aout     = r_aout;
  assign dout     = w_rd_t4 ? w_data_t4 : r_data;
  assign ext_dout = r_data;
  assign opcode   = ctl_ir_we ? w_data_t4 : r_opcode;
  assign bank_cb  = r_bank_cb;
  assign ill_op   = r_ill_op;

endmodule
`default_nettype wire

// File: tb/tb_sm83_bus_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sm83_bus_ctrl : directed self-checking bench for sm83_bus_ctrl        |
// | Revision         : 1.0                                                   |
// +--------------------------------------------------------------------------+
module tb_sm83_bus_ctrl;

  logic        clk;
  logic        reset;
  logic        t1, t2, t3, t4, stall;
  logic        mread, mwrite, ext_ready;
  logic        rd, wr, bus_err;
  logic [15:0] ain, aout;
  logic        apin_we;
  logic [7:0]  din, dout, ext_dout, ext_din, vec_data, opcode;
  logic        dl_we, vec_sel, ctl_zero_data_oe, ctl_ir_we;
  logic        ctl_ir_bank_we, ctl_ir_bank_cb_set, bank_cb, ill_op;

  int n_checks = 0;
  int n_pass   = 0;

  sm83_bus_ctrl #(
    .ADDR_W(16), .DATA_W(8), .HI_CLR_BITS(8), .MAX_WAIT(15)
  ) dut (
    .clk(clk), .reset(reset),
    .t1(t1), .t2(t2), .t3(t3), .t4(t4), .stall(stall),
    .mread(mread), .mwrite(mwrite), .ext_ready(ext_ready),
    .rd(rd), .wr(wr), .bus_err(bus_err),
    .ain(ain), .apin_we(apin_we), .aout(aout),
    .din(din), .dl_we(dl_we), .dout(dout), .ext_dout(ext_dout),
    .ext_din(ext_din), .vec_sel(vec_sel), .vec_data(vec_data),
    .ctl_zero_data_oe(ctl_zero_data_oe), .ctl_ir_we(ctl_ir_we),
    .ctl_ir_bank_we(ctl_ir_bank_we), .ctl_ir_bank_cb_set(ctl_ir_bank_cb_set),
    .opcode(opcode), .bank_cb(bank_cb), .ill_op(ill_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to the next T4, sampling just after each falling edge.
  task automatic go_t4(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (t4) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [9:0] flags;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    flags = {t1, t2, t3, t4, stall, rd, wr, bus_err, bank_cb, ill_op};
    n_checks++;
    if (flags !== 10'b0001000000) $display("FAIL reset_flags: got %b want %b", flags, 10'b0001000000);
    else n_pass++;
    n_checks++;
    if (aout !== 16'h0000) $display("FAIL reset_aout: got %h want 0000", aout);
    else n_pass++;
    n_checks++;
    if ({ext_dout, dout, opcode} !== 24'h0) $display("FAIL reset_data: got %h want 000000", {ext_dout, dout, opcode});
    else n_pass++;
  endtask

  task automatic test_zero_wait_read();
    int n;
    bit ok;
    reset = 1'b0; mread = 1'b1; ext_din = 8'h3C; ain = 16'hABCD; apin_we = 1'b1;
    @(negedge clk); #1;
    mread = 1'b0; apin_we = 1'b0; ain = 16'h0;
    n_checks++;
    if ({t1, rd, aout} !== {1'b1, 1'b1, 16'hABCD}) $display("FAIL read_start: got t1=%b rd=%b aout=%h want 1 1 abcd", t1, rd, aout);
    else n_pass++;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (rd) n++;
      if (t4) break;
      @(negedge clk); #1;
    end
    n_checks++;
    if (n != 4 || !t4) $display("FAIL read_len: got %0d want 4", n);
    else n_pass++;
    n_checks++;
    if (dout !== 8'h3C) $display("FAIL read_dout_t4: got %h want 3c", dout);
    else n_pass++;
    @(negedge clk); #1;
    n_checks++;
    if ({aout, ext_dout, rd} !== {16'h00CD, 8'h3C, 1'b0}) $display("FAIL read_after: got aout=%h data=%h rd=%b want 00cd 3c 0", aout, ext_dout, rd);
    else n_pass++;
    go_t4(ok);
    n_checks++;
    if (!ok) $display("FAIL read_t4_reach: got timeout want t4");
    else n_pass++;
    apin_we = 1'b1; ain = 16'h1234;
    @(negedge clk); #1;
    apin_we = 1'b0;
    n_checks++;
    if (aout !== 16'h1234) $display("FAIL apin_we_over_clear: got %h want 1234", aout);
    else n_pass++;
  endtask

  task automatic test_wait_write();
    int cyc, stalls, t3n, errs;
    bit stable, ok;
    go_t4(ok);
    n_checks++;
    if (!ok) $display("FAIL wait_t4_reach: got timeout want t4");
    else n_pass++;
    mwrite = 1'b1; dl_we = 1'b1; din = 8'h5A; ext_ready = 1'b0;
    @(negedge clk); #1;
    mwrite = 1'b0; dl_we = 1'b0;
    cyc = 0; stalls = 0; t3n = 0; errs = 0; stable = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (t3) begin
        t3n++;
        if (t3n == 4) ext_ready = 1'b1;
      end
      #1;
      if (wr) cyc++;
      if (stall) stalls++;
      if (ext_dout !== 8'h5A) stable = 1'b0;
      if (bus_err) errs++;
      if (t4) break;
      @(negedge clk); #1;
    end
    ext_ready = 1'b1;
    n_checks++;
    if (cyc != 7) $display("FAIL wait_len: got %0d want 7", cyc);
    else n_pass++;
    n_checks++;
    if (stalls != 3) $display("FAIL wait_stalls: got %0d want 3", stalls);
    else n_pass++;
    n_checks++;
    if (!stable || errs != 0) $display("FAIL wait_dout_err: got stable=%b errs=%0d want 1 0", stable, errs);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int cyc, stalls;
    bit ok;
    go_t4(ok);
    n_checks++;
    if (!ok) $display("FAIL tmo_t4_reach: got timeout want t4");
    else n_pass++;
    mread = 1'b1; ext_ready = 1'b0; ext_din = 8'h77;
    @(negedge clk); #1;
    mread = 1'b0;
    cyc = 0; stalls = 0;
    for (int i = 0; i < 40; i++) begin
      if (rd) cyc++;
      if (stall) stalls++;
      if (t4) break;
      @(negedge clk); #1;
    end
    n_checks++;
    if (cyc != 19 || stalls != 15) $display("FAIL tmo_len: got cyc=%0d stalls=%0d want 19 15", cyc, stalls);
    else n_pass++;
    n_checks++;
    if ({bus_err, dout} !== {1'b1, 8'hFF}) $display("FAIL tmo_t4: got err=%b dout=%h want 1 ff", bus_err, dout);
    else n_pass++;
    ext_ready = 1'b1;
    @(negedge clk); #1;
    n_checks++;
    if ({bus_err, ext_dout, rd} !== {1'b0, 8'hFF, 1'b0}) $display("FAIL tmo_after: got err=%b data=%h rd=%b want 0 ff 0", bus_err, ext_dout, rd);
    else n_pass++;
  endtask

  task automatic test_ir_vector();
    bit ok1, ok2;
    go_t4(ok1);
    mread = 1'b1;
    @(negedge clk); #1;
    mread = 1'b0;
    go_t4(ok2);
    n_checks++;
    if (!(ok1 && ok2)) $display("FAIL ir_t4_reach: got timeout want t4");
    else n_pass++;
    vec_sel = 1'b1; vec_data = 8'h40; ext_din = 8'h11; ctl_ir_we = 1'b1;
    #1;
    n_checks++;
    if ({opcode, dout} !== {8'h40, 8'h40}) $display("FAIL ir_same_cycle: got op=%h dout=%h want 40 40", opcode, dout);
    else n_pass++;
    @(negedge clk); #1;
    ctl_ir_we = 1'b0; vec_sel = 1'b0; ctl_ir_bank_we = 1'b1; ctl_ir_bank_cb_set = 1'b1;
    #1;
    n_checks++;
    if ({opcode, ext_dout} !== {8'h40, 8'h40}) $display("FAIL ir_held: got op=%h data=%h want 40 40", opcode, ext_dout);
    else n_pass++;
    @(negedge clk); #1;
    ctl_ir_bank_we = 1'b0;
    n_checks++;
    if (bank_cb !== 1'b1) $display("FAIL bank_set: got %b want 1", bank_cb);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    bit ok;
    go_t4(ok);
    mread = 1'b1; mwrite = 1'b1; ext_din = 8'h9C;
    @(negedge clk); #1;
    mread = 1'b0; mwrite = 1'b0;
    n_checks++;
    if ({rd, wr} !== 2'b10) $display("FAIL both_req: got rd,wr=%b want 10", {rd, wr});
    else n_pass++;
    ctl_zero_data_oe = 1'b1; dl_we = 1'b1; din = 8'hAA; ctl_ir_we = 1'b1;
    #1;
    n_checks++;
    if (opcode !== 8'h00) $display("FAIL zero_ir_comb: got %h want 00", opcode);
    else n_pass++;
    @(negedge clk); #1;
    ctl_zero_data_oe = 1'b0; dl_we = 1'b0; ctl_ir_we = 1'b0;
    #1;
    n_checks++;
    if ({ext_dout, opcode} !== 16'h0000) $display("FAIL zero_over_dl: got data=%h op=%h want 00 00", ext_dout, opcode);
    else n_pass++;
    go_t4(ok);
    n_checks++;
    if (!ok || {dout, bus_err, wr} !== {8'h9C, 1'b0, 1'b0}) $display("FAIL both_req_t4: got dout=%h err=%b wr=%b want 9c 0 0", dout, bus_err, wr);
    else n_pass++;
  endtask

  task automatic test_illegal();
    bit ok1, ok2;
    go_t4(ok1);
    mread = 1'b1; ext_din = 8'hD3;
    @(negedge clk); #1;
    mread = 1'b0;
    go_t4(ok2);
    ctl_ir_we = 1'b1;
    @(negedge clk); #1;
    ctl_ir_we = 1'b0;
    n_checks++;
    if (!(ok1 && ok2) || {ill_op, opcode} !== {1'b0, 8'hD3}) $display("FAIL ill_cb_bank: got ill=%b op=%h want 0 d3", ill_op, opcode);
    else n_pass++;
    ctl_ir_bank_we = 1'b1; ctl_ir_bank_cb_set = 1'b0;
    @(negedge clk); #1;
    ctl_ir_bank_we = 1'b0;
    n_checks++;
    if (bank_cb !== 1'b0) $display("FAIL bank_clr: got %b want 0", bank_cb);
    else n_pass++;
    go_t4(ok1);
    mread = 1'b1;
    @(negedge clk); #1;
    mread = 1'b0;
    go_t4(ok2);
    ctl_ir_we = 1'b1;
    @(negedge clk); #1;
    ctl_ir_we = 1'b0;
    n_checks++;
    if (!(ok1 && ok2) || ill_op !== 1'b1) $display("FAIL ill_set: got %b want 1", ill_op);
    else n_pass++;
    go_t4(ok1);
    mread = 1'b1;
    @(negedge clk); #1;
    mread = 1'b0;
    n_checks++;
    if ({rd, wr} !== 2'b00) $display("FAIL ill_no_rd: got rd,wr=%b want 00", {rd, wr});
    else n_pass++;
    go_t4(ok2);
    mwrite = 1'b1;
    @(negedge clk); #1;
    mwrite = 1'b0;
    n_checks++;
    if (!(ok1 && ok2) || {rd, wr, ill_op, t1} !== 4'b0011) $display("FAIL ill_no_wr: got rd,wr,ill,t1=%b want 0011", {rd, wr, ill_op, t1});
    else n_pass++;
  endtask

  task automatic test_reset_stall();
    int n;
    bit ok;
    logic [7:0] flags;
    reset = 1'b1;
    @(negedge clk); #1;
    n_checks++;
    if ({ill_op, t4} !== 2'b01) $display("FAIL rst_clears_ill: got ill,t4=%b want 01", {ill_op, t4});
    else n_pass++;
    reset = 1'b0; mread = 1'b1; ext_ready = 1'b0;
    @(negedge clk); #1;
    mread = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (stall) n++;
      if (n == 2) break;
      @(negedge clk); #1;
    end
    n_checks++;
    if (n != 2 || rd !== 1'b1) $display("FAIL stall_seen: got n=%0d rd=%b want 2 1", n, rd);
    else n_pass++;
    reset = 1'b1;
    @(negedge clk); #1;
    flags = {t1, t2, t3, t4, stall, rd, wr, bus_err};
    n_checks++;
    if (flags !== 8'b00010000) $display("FAIL rst_in_stall: got %b want 00010000", flags);
    else n_pass++;
    reset = 1'b0; ext_ready = 1'b1;
    go_t4(ok);
    n_checks++;
    if (!ok || {bus_err, rd} !== 2'b00) $display("FAIL rst_no_err: got err,rd=%b want 00", {bus_err, rd});
    else n_pass++;
  endtask

  initial begin
    reset = 1'b1; mread = 1'b0; mwrite = 1'b0; ext_ready = 1'b1;
    ain = '0; apin_we = 1'b0; din = '0; dl_we = 1'b0; ext_din = '0;
    vec_sel = 1'b0; vec_data = '0; ctl_zero_data_oe = 1'b0; ctl_ir_we = 1'b0;
    ctl_ir_bank_we = 1'b0; ctl_ir_bank_cb_set = 1'b0;
    test_reset();
    test_zero_wait_read();
    test_wait_write();
    test_timeout();
    test_ir_vector();
    test_simultaneous();
    test_illegal();
    test_reset_stall();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
